rle_stream_decoder: RTL

RLE_STREAM_DECODER -- requirements
Module: rle_stream_decoder

---
 rtl/rle_stream_decoder.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/rle_stream_decoder.sv
`default_nettype none
// ============================================================================
// Module   : rle_stream_decoder
// Brief    : Run-length stream decoder. It reads a header word count N, then
//            N {count, symbol} records, and expands each record into a small
//            output FIFO with valid/accept handshakes on both sides.
// Revision : 1.0 - initial release
// ============================================================================
module rle_stream_decoder #(
  parameter int DATA_W     = 8,
  parameter int LEN_WORDS  = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rd,
  input  logic [DATA_W-1:0] data_in,
  output logic              reading,
  output logic [DATA_W-1:0] data_out,
  output logic              sending,
  input  logic              received,
  output logic              done
);

  localparam int NW = DATA_W * LEN_WORDS;
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int HW = $clog2(LEN_WORDS + 1);

  typedef enum logic [2:0] {
    HDR    = 3'd0,
    CNT    = 3'd1,
    SYM    = 3'd2,
    EXPAND = 3'd3,
    DONE   = 3'd4
  } state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [NW-1:0]     r_n;
  logic [NW-1:0]     r_rec;
  logic [DATA_W-1:0] r_run;
  logic [DATA_W-1:0] r_sym;
  logic [HW-1:0]     r_hdr_cnt;

  logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]     r_wptr;
  logic [AW-1:0]     r_rptr;
  logic [AW:0]       r_count;

  logic              w_accept;
  logic              w_pop;
  logic              w_push;
  logic              w_full;
  logic              w_hdr_last;
  logic              w_rec_last;
  logic [NW-1:0]     w_rec_inc;
  logic [NW-1:0]     w_n_shift;

  // Reading is gated by reset so it drops the instant reset asserts.
  assign reading    = reset && (r_state == HDR || r_state == CNT || r_state == SYM);
  assign w_accept   = rd && reading;
  assign sending    = (r_count != '0);
  assign w_pop      = sending && received;
  assign w_full     = (r_count == (AW+1)'(FIFO_DEPTH));
  assign data_out   = sending ? r_mem[r_rptr] : '0;
  // DONE is terminal and the FIFO cannot refill there, so this stays high.
  assign done       = (r_state == DONE) && (r_count == '0);
  assign w_hdr_last = (r_hdr_cnt == HW'(LEN_WORDS - 1));
  assign w_rec_inc  = r_rec + NW'(1);
  assign w_rec_last = (w_rec_inc == r_n);
  assign w_n_shift  = (r_n << DATA_W) | NW'(data_in);

  // Next-state selection and the push strobe for the expansion phase.
  always_comb begin
    w_state_next = r_state;
    w_push       = 1'b0;
    case (r_state)
      HDR: begin
        if (w_accept && w_hdr_last) begin
          w_state_next = (w_n_shift != '0) ? CNT : DONE;
        end
      end
      CNT: begin
        if (w_accept) w_state_next = SYM;
      end
      SYM: begin
        if (w_accept) begin
          if (r_run == '0) w_state_next = w_rec_last ? DONE : CNT;
          else             w_state_next = EXPAND;
        end
      end
      EXPAND: begin
        // A full FIFO still takes a push when the head is popped this cycle.
        if (!w_full || w_pop) begin
          w_push = 1'b1;
          if (r_run == DATA_W'(1)) w_state_next = w_rec_last ? DONE : CNT;
        end
      end
      DONE:    w_state_next = DONE;
      default: w_state_next = HDR;
    endcase
  end

  // State register plus header, run, symbol and record-counter datapath.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= HDR;
      r_n       <= '0;
      r_rec     <= '0;
      r_run     <= '0;
      r_sym     <= '0;
      r_hdr_cnt <= '0;
    end else begin
      r_state <= w_state_next;
      case (r_state)
        HDR: begin
          if (w_accept) begin
            r_n       <= w_n_shift;
            r_hdr_cnt <= w_hdr_last ? '0 : r_hdr_cnt + HW'(1);
          end
        end
        CNT: begin
          if (w_accept) r_run <= data_in;
        end
        SYM: begin
          if (w_accept) begin
            r_sym <= data_in;
            if (r_run == '0) r_rec <= w_rec_inc;
          end
        end
        EXPAND: begin
          if (w_push) begin
            r_run <= r_run - DATA_W'(1);
            if (r_run == DATA_W'(1)) r_rec <= w_rec_inc;
          end
        end
        default: ;
      endcase
    end
  end

  // FIFO storage; contents are don't-care while the occupancy says empty.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= r_sym;
  end

  // FIFO pointers and occupancy; pointers wrap naturally at the power of two.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire
